// File: rtl/ex_hazard_ctrl_pkg.sv
// rtl/ex_hazard_ctrl_pkg.sv - shared opcodes, state and forward-select encodings
package ex_hazard_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_UPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_B) || (op == OP_S);
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// rtl/ex_hazard_ctrl_fwd_sel.sv - operand forward source match, MEM over WB, x0 never forwards
module ex_hazard_ctrl_fwd_sel
  import ex_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_mem_valid,
  input  logic [4:0] i_mem_rd,
  input  logic       i_wb_valid,
  input  logic [4:0] i_wb_rd,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_mem_valid && (i_mem_rd != 5'd0) && (i_mem_rd == i_src)) begin
      o_sel = FWD_MEM;
    end else if (i_wb_valid && (i_wb_rd != 5'd0) && (i_wb_rd == i_src)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX issue sequencer: forwarding, load-use bubble, memory freeze, redirect flush
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic [6:0]       i_id_opcode,
  input  logic             i_ex_valid,
  input  logic [4:0]       i_ex_rd,
  input  logic [6:0]       i_ex_opcode,
  input  logic             i_mem_valid,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_mem_busy,
  input  logic             i_redirect,
  output logic [1:0]       o_fwd_rs1_sel,
  output logic [1:0]       o_fwd_rs2_sel,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_bubble_ex,
  output logic             o_flush_id,
  output logic             o_freeze,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             stall_if, stall_id, bubble_ex, flush_id, freeze;

  ex_hazard_ctrl_fwd_sel u_fwd_rs1 (
    .i_src       (i_id_rs1),
    .i_mem_valid (i_mem_valid),
    .i_mem_rd    (i_mem_rd),
    .i_wb_valid  (i_wb_valid),
    .i_wb_rd     (i_wb_rd),
    .o_sel       (o_fwd_rs1_sel)
  );

  ex_hazard_ctrl_fwd_sel u_fwd_rs2 (
    .i_src       (i_id_rs2),
    .i_mem_valid (i_mem_valid),
    .i_mem_rd    (i_mem_rd),
    .i_wb_valid  (i_wb_valid),
    .i_wb_rd     (i_wb_rd),
    .o_sel       (o_fwd_rs2_sel)
  );

  always_comb begin
    load_use = i_ex_valid && (i_ex_opcode == OP_LOAD) && (i_ex_rd != 5'd0) && i_id_valid &&
               ((uses_rs1(i_id_opcode) && (i_id_rs1 == i_ex_rd)) ||
                (uses_rs2(i_id_opcode) && (i_id_rs2 == i_ex_rd)));
  end

  always_comb begin
    state_d   = state_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    // A busy memory freezes the whole pipe in every state; a held redirect is replayed from EX afterwards.
    unique case (state_q)
      ST_RUN: begin
        if (i_mem_busy) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
        end else if (i_redirect) begin
          flush_id = 1'b1;
          state_d  = ST_FLUSH;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          state_d   = ST_LU_STALL;
        end
      end
      ST_LU_STALL: begin
        freeze  = i_mem_busy;
        state_d = i_mem_busy ? ST_MEM_WAIT : ST_RUN;
      end
      ST_MEM_WAIT: begin
        freeze  = i_mem_busy;
        state_d = i_mem_busy ? ST_MEM_WAIT : ST_RUN;
      end
      ST_FLUSH: begin
        bubble_ex = 1'b1;
        freeze    = i_mem_busy;
        state_d   = i_mem_busy ? ST_MEM_WAIT : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Controls are forced quiet while reset is held so a busy memory cannot freeze a resetting pipe.
  assign o_stall_if  = stall_if  & rst_n;
  assign o_stall_id  = stall_id  & rst_n;
  assign o_bubble_ex = bubble_ex & rst_n;
  assign o_flush_id  = flush_id  & rst_n;
  assign o_freeze    = freeze    & rst_n;
  assign o_state     = state_q;
  assign o_stall_cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if ((o_stall_id || o_freeze) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - directed self-checking bench for ex_hazard_ctrl
module tb_ex_hazard_ctrl;
  import ex_hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, ex_valid, mem_valid, wb_valid, mem_busy, redirect;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic [6:0] id_opcode, ex_opcode;

  logic [1:0]  fwd1, fwd2, st, fwd1_b, fwd2_b, st_b;
  logic        stall_if, stall_id, bubble_ex, flush_id, freeze;
  logic        stall_if_b, stall_id_b, bubble_ex_b, flush_id_b, freeze_b;
  logic [15:0] cnt;
  logic [1:0]  cnt_b;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_opcode(id_opcode),
    .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_opcode(ex_opcode),
    .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .i_mem_busy(mem_busy), .i_redirect(redirect),
    .o_fwd_rs1_sel(fwd1), .o_fwd_rs2_sel(fwd2),
    .o_stall_if(stall_if), .o_stall_id(stall_id), .o_bubble_ex(bubble_ex),
    .o_flush_id(flush_id), .o_freeze(freeze), .o_state(st), .o_stall_cnt(cnt)
  );

  ex_hazard_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_opcode(id_opcode),
    .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_opcode(ex_opcode),
    .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .i_mem_busy(mem_busy), .i_redirect(redirect),
    .o_fwd_rs1_sel(fwd1_b), .o_fwd_rs2_sel(fwd2_b),
    .o_stall_if(stall_if_b), .o_stall_id(stall_id_b), .o_bubble_ex(bubble_ex_b),
    .o_flush_id(flush_id_b), .o_freeze(freeze_b), .o_state(st_b), .o_stall_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic ctrl(input string tag, input logic [4:0] exp);
    chk(tag, 32'({stall_if, stall_id, bubble_ex, flush_id, freeze}), 32'(exp));
  endtask

  task automatic clr();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_opcode = OP_I;
    ex_valid = 1'b0; ex_rd = 5'd0; ex_opcode = OP_I;
    mem_valid = 1'b0; mem_rd = 5'd0; wb_valid = 1'b0; wb_rd = 5'd0;
    mem_busy = 1'b0; redirect = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctrl vector order: {stall_if, stall_id, bubble_ex, flush_id, freeze}
  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    chk("rst_state", 32'(st), 0);
    chk("rst_cnt", 32'(cnt), 0);
    ctrl("rst_ctrl", 5'b00000);
    chk("rst_fwd", 32'({fwd1, fwd2}), 32'b0000);
    tick();
    rst_n = 1'b1;
    tick();

    id_valid = 1'b1; id_opcode = OP_R; id_rs1 = 5'd5; id_rs2 = 5'd5;
    mem_valid = 1'b1; mem_rd = 5'd5; wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    chk("fwd_mem_prio", 32'({fwd1, fwd2}), 32'b0101);
    mem_valid = 1'b0;
    #1;
    chk("fwd_wb_only", 32'({fwd1, fwd2}), 32'b1010);
    mem_valid = 1'b1; id_rs2 = 5'd6; wb_rd = 5'd6;
    #1;
    chk("fwd_split", 32'({fwd1, fwd2}), 32'b0110);
    mem_valid = 1'b0; wb_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    chk("fwd_x0", 32'({fwd1, fwd2}), 32'b0000);
    ctrl("fwd_ctrl_quiet", 5'b00000);

    clr();
    ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_rd = 5'd3;
    id_valid = 1'b1; id_opcode = OP_R; id_rs1 = 5'd3; id_rs2 = 5'd1;
    #1;
    ctrl("lu_detect", 5'b11100);
    chk("lu_state0", 32'(st), 0);
    tick();
    ex_valid = 1'b0; mem_valid = 1'b1; mem_rd = 5'd3;
    #1;
    chk("lu_state1", 32'(st), 1);
    ctrl("lu_stall_quiet", 5'b00000);
    chk("lu_cnt", 32'(cnt), 1);
    tick();
    mem_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd3;
    #1;
    chk("lu_back_run", 32'(st), 0);
    chk("lu_fwd_wb", 32'(fwd1), 32'b10);
    ctrl("lu_no_second", 5'b00000);

    clr();
    ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_rd = 5'd0;
    id_valid = 1'b1; id_opcode = OP_R; id_rs1 = 5'd0; id_rs2 = 5'd0;
    #1;
    ctrl("lu_x0", 5'b00000);
    ex_rd = 5'd7; id_opcode = OP_I; id_rs1 = 5'd1; id_rs2 = 5'd7;
    #1;
    ctrl("lu_rs2_unused", 5'b00000);
    id_opcode = OP_LUI; id_rs1 = 5'd7;
    #1;
    ctrl("lu_lui_rs1", 5'b00000);
    id_opcode = OP_S; id_rs1 = 5'd1;
    #1;
    ctrl("lu_store_rs2", 5'b11100);
    ex_opcode = OP_I;
    #1;
    ctrl("lu_non_load", 5'b00000);

    clr();
    ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_rd = 5'd3;
    id_valid = 1'b1; id_opcode = OP_R; id_rs1 = 5'd3;
    redirect = 1'b1;
    #1;
    ctrl("redir_over_lu", 5'b00010);
    tick();
    redirect = 1'b0;
    #1;
    chk("flush_state", 32'(st), 3);
    ctrl("flush_bubble", 5'b00100);
    tick();
    clr();
    #1;
    chk("flush_done", 32'(st), 0);
    chk("flush_cnt", 32'(cnt), 1);

    mem_busy = 1'b1;
    #1;
    ctrl("busy1", 5'b00001);
    tick();
    redirect = 1'b1;
    #1;
    chk("busy2_state", 32'(st), 2);
    ctrl("busy2_redir", 5'b00001);
    tick();
    redirect = 1'b0;
    #1;
    ctrl("busy3", 5'b00001);
    chk("cnt_small_sat", 32'(cnt_b), 3);
    tick();
    mem_busy = 1'b0;
    #1;
    ctrl("busy_done", 5'b00000);
    chk("busy_cnt", 32'(cnt), 4);
    tick();
    chk("busy_run", 32'(st), 0);
    chk("cnt_small_hold", 32'(cnt_b), 3);
    chk("busy_cnt_hold", 32'(cnt), 4);

    mem_busy = 1'b1;
    tick();
    chk("pre_rst_state", 32'(st), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(st), 0);
    chk("arst_cnt", 32'(cnt), 0);
    ctrl("arst_ctrl", 5'b00000);
    mem_busy = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(st), 0);
    chk("post_rst_cnt", 32'(cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
# ex_hazard_ctrl

Pipeline sequencer for the Execute stage: decides each cycle whether the instruction in ID may issue into EX, selects forwarding sources for EX operands, inserts bubbles for load-use hazards, freezes the pipe while data memory is busy, and flushes wrong-path instructions after a taken branch or jump. Sits beside the Execute stage, driving its operand muxes and the IF/ID/EX pipeline-register enables, and counts stall cycles for performance monitoring.

## Interface
- `CNT_W`, 16: width of the saturating stall counter.
- `clk` input 1: core clock.
- `rst_n` input 1: asynchronous active-low reset.
- `i_id_valid` input 1: valid instruction in ID.
- `i_id_rs1`, `i_id_rs2` input 5 each: ID source registers.
- `i_id_opcode` input 7: ID opcode (`R`, `B`, `S`, `I`, `LOAD`, `JALR`, …).
- `i_ex_valid` input 1; `i_ex_rd` input 5; `i_ex_opcode` input 7: instruction in EX.
- `i_mem_valid` input 1; `i_mem_rd` input 5: instruction in MEM.
- `i_wb_valid` input 1; `i_wb_rd` input 5: instruction in WB.
- `i_mem_busy` input 1: data memory has not completed the current access.
- `i_redirect` input 1: EX resolved a taken branch or jump this cycle.
- `o_fwd_rs1_sel`, `o_fwd_rs2_sel` output 2 each: 00 regfile, 01 MEM result, 10 WB result; 11 unused.
- `o_stall_if`, `o_stall_id` output 1 each: hold the PC and the IF/ID register.
- `o_bubble_ex` output 1: load a NOP into ID/EX.
- `o_flush_id` output 1: invalidate IF/ID.
- `o_freeze` output 1: hold every pipeline register, including EX/MEM and MEM/WB.
- `o_state` output 2: current FSM state, for debug.
- `o_stall_cnt` output `CNT_W`: saturating count of cycles with `o_stall_id` or `o_freeze` high.

## Operation
- States: RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3.
- Source-use: rs1 is used by all opcodes except `LUI` and `JAL`. rs2 is used only by `R`, `B` and `S`. Register x0 never creates a hazard or a forward.
- Forwarding, combinational, applied to the instruction currently in EX: select MEM when `i_mem_valid`, rd≠0 and rd matches the source. Otherwise select WB under the same rule. MEM takes priority over WB.
- Load-use hazard: `i_ex_valid`, `i_ex_opcode`==`LOAD`, `i_ex_rd`≠0, and `i_id_valid` with a used source equal to `i_ex_rd`.
- Event priority each cycle is `i_mem_busy` > `i_redirect` > load-use.
- RUN:
  - `i_mem_busy` → assert `o_freeze`; go to MEM_WAIT.
  - `i_redirect` → assert `o_flush_id`; go to FLUSH.
  - Load-use → assert `o_stall_if`, `o_stall_id` and `o_bubble_ex`; go to LU_STALL.
  - Otherwise stay in RUN with all control outputs low.
- LU_STALL: the load is now in MEM. Outputs are low; the consumer issues and takes its operand by forwarding from WB in the following cycle. `i_mem_busy` → MEM_WAIT. Otherwise go to RUN. No second stall for the same load.
- MEM_WAIT: `o_freeze`=1 while `i_mem_busy`. On the first cycle with `i_mem_busy`=0, drop the freeze and return to RUN.
- FLUSH: assert `o_bubble_ex` so the wrong-path ID instruction never enters EX. Then go to RUN; `i_mem_busy` → MEM_WAIT. A load-use detected in this cycle is ignored because that instruction is wrong-path.
- Overlapping events:
  - Redirect together with load-use: flush wins and no stall is inserted.
  - Redirect during `i_mem_busy`: the freeze wins. `i_redirect` is held by the frozen EX register and is acted on after MEM_WAIT.
- `o_stall_cnt` increments by 1 per qualifying cycle and saturates at all-ones; it does not wrap.

## Timing
- All control outputs are combinational from the current state and inputs. Only the state and the counter are registered.
- Reset (async, `rst_n`=0): state RUN, `o_stall_cnt`=0. All control outputs are 0 and the forward selects are 00 (given valid=0 inputs).
- A reset mid-stall or mid-freeze returns to RUN immediately. No pending event survives reset.
- Latencies:
  - Load-use costs exactly 1 bubble.
  - A taken redirect costs 2 killed slots: IF/ID in the redirect cycle, ID/EX in the following cycle.
  - A memory wait costs N freeze cycles for N busy cycles.

## Structure
- Opcode constants (`R`, `B`, `S`, `LOAD`, `LUI`, `JAL`, `JALR`, `UPC`) and the state/forward-select encodings belong in the shared defines header used by every stage.
- One natural sub-module, `fwd_sel`: pure combinational source matching, instantiated once per operand.

## Test plan
- Forward priority: x5 written by both MEM and WB; EX `ADD x6,x5,x5` → both selects 01. Then with only WB writing x5 → both selects 10.
- Load-use: `LW x3` in EX, `ADD x4,x3,x1` in ID → 1 cycle of stall_if/stall_id/bubble_ex, then state RUN and rs1 select 10 next cycle.
- x0 and unused source: `LW x0` followed by a consumer of x0 → no stall. `LW x7` followed by `ADDI x8,x1,7` where x7 appears only in the rs2 field → no stall.
- Redirect during load-use: `i_redirect`=1 while a load-use is present → `o_flush_id`=1 and no stall; next cycle `o_bubble_ex`=1, state FLUSH.
- Memory wait: `i_mem_busy` high for 3 cycles → `o_freeze` high for exactly 3 cycles and `o_stall_cnt` +3. Repeat with `CNT_W`=2 → counter holds at 3.
- Async reset: assert `rst_n`=0 mid-MEM_WAIT → state 0, counter 0 and freeze low immediately, without waiting for a clock edge.
